// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StCapture = ST_CAPTURE,
    StHold    = ST_HOLD
  } state_e;

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set bit of req scanning from ptr upward, mod 8.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SEL_W-1:0]  off;

  always_comb begin
    // Rotate so that bit ptr lands at position 0, then lowest set bit wins.
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin sequencer for the shared 8-to-1 mux: select, capture, and hand off
// downstream with valid/ready, dropping the word if the consumer stalls too long.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] mux_data,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  grant,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             timeout_err,
  output logic             busy
);

  state_e           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      sel         <= '0;
      grant       <= '0;
      out_data    <= '0;
      out_src     <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            sel     <= pick_idx;
            // Grant is registered so it is high exactly for the CAPTURE cycle.
            grant   <= NREQ'(1) << pick_idx;
            state_q <= StCapture;
          end
        end
        StCapture: begin
          grant     <= '0;
          out_data  <= mux_data;
          out_src   <= sel;
          out_valid <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr_q     <= sel + SEL_W'(1);
            state_q   <= StIdle;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            out_valid   <= 1'b0;
            timeout_err <= 1'b1;
            ptr_q       <= sel + SEL_W'(1);
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with a behavioural model of the shared mux.
module tb_mux8_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] mux_data;
  logic [2:0]  sel;
  logic [7:0]  grant;
  logic [15:0] out_data;
  logic [2:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic        timeout_err;
  logic        busy;

  logic [15:0] dmem [8];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign mux_data = dmem[sel];

  mux8_rr_arbiter #(
    .WIDTH   (16),
    .TIMEOUT (4),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .mux_data    (mux_data),
    .sel         (sel),
    .grant       (grant),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) dmem[i] = 16'hA000 + 16'(i);
    do_reset();
    compared++; if (sel !== 3'd0) begin mismatched++; $display("FAIL reset_sel got %0d want 0", sel); end
    compared++; if (grant !== 8'h00) begin mismatched++; $display("FAIL reset_grant got %h want 00", grant); end
    compared++; if (out_data !== 16'h0) begin mismatched++; $display("FAIL reset_data got %h want 0000", out_data); end
    compared++; if (out_src !== 3'd0) begin mismatched++; $display("FAIL reset_src got %0d want 0", out_src); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", out_valid); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %b want 0", timeout_err); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    dmem[2] = 16'hBEEF; out_ready = 1'b1; req = 8'b0000_0100;
    tick();
    compared++; if (sel !== 3'd2) begin mismatched++; $display("FAIL single_sel got %0d want 2", sel); end
    compared++; if (grant !== 8'h04) begin mismatched++; $display("FAIL single_grant got %h want 04", grant); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy got %b want 1", busy); end
    req = '0;
    tick();
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid got %b want 1", out_valid); end
    compared++; if (out_data !== 16'hBEEF) begin mismatched++; $display("FAIL single_data got %h want beef", out_data); end
    compared++; if (out_src !== 3'd2) begin mismatched++; $display("FAIL single_src got %0d want 2", out_src); end
    compared++; if (grant !== 8'h00) begin mismatched++; $display("FAIL single_grant_off got %h want 00", grant); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_done_valid got %b want 0", out_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_idle got %b want 0", busy); end
    // ptr should now be 3: bits 0,1,3 requested, 3 must win
    req = 8'b0000_1011;
    tick();
    compared++; if (sel !== 3'd3) begin mismatched++; $display("FAIL single_ptr3 got %0d want 3", sel); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    int exp;
    for (int i = 0; i < 8; i++) dmem[i] = 16'h5A00 + 16'(i * 17);
    do_reset();
    out_ready = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp = k % 8;
      tick();
      compared++; if (grant !== (8'h01 << exp)) begin mismatched++; $display("FAIL rr_grant[%0d] got %h want %h", k, grant, 8'h01 << exp); end
      tick();
      compared++; if (out_valid !== 1'b1 || out_src !== 3'(exp)) begin mismatched++; $display("FAIL rr_src[%0d] got v=%b %0d want v=1 %0d", k, out_valid, out_src, exp); end
      compared++; if (out_data !== dmem[exp]) begin mismatched++; $display("FAIL rr_data[%0d] got %h want %h", k, out_data, dmem[exp]); end
      tick();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rr_gap[%0d] got %b want 0", k, out_valid); end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; req = 8'h20;
    tick(); req = '0; tick(); tick();  // requester 5 served, ptr now 6
    req = 8'b0010_0001;
    tick();
    compared++; if (sel !== 3'd0) begin mismatched++; $display("FAIL wrap_first got %0d want 0", sel); end
    tick(); tick();
    tick();
    compared++; if (sel !== 3'd5) begin mismatched++; $display("FAIL wrap_second got %0d want 5", sel); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    dmem[1] = 16'h1234; out_ready = 1'b0; req = 8'h02;
    tick(); req = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL to_valid[%0d] got %b want 1", c, out_valid); end
      compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL to_err_early[%0d] got %b want 0", c, timeout_err); end
    end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL to_drop got %b want 0", out_valid); end
    compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_err got %b want 1", timeout_err); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL to_idle got %b want 0", busy); end
    // a later successful transfer leaves the sticky flag set
    out_ready = 1'b1; req = 8'h08;
    tick(); req = '0; tick();
    compared++; if (out_src !== 3'd3 || out_valid !== 1'b1) begin mismatched++; $display("FAIL to_next got v=%b %0d want v=1 3", out_valid, out_src); end
    tick();
    compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_sticky got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_in_hold();
    // timeout_err is still 1 from the previous test; ptr is 4
    out_ready = 1'b0; req = 8'h40;
    tick(); req = '0; tick();
    compared++; if (out_valid !== 1'b1 || out_src !== 3'd6) begin mismatched++; $display("FAIL rh_hold got v=%b %0d want v=1 6", out_valid, out_src); end
    do_reset();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rh_valid got %b want 0", out_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rh_busy got %b want 0", busy); end
    compared++; if (grant !== 8'h00) begin mismatched++; $display("FAIL rh_grant got %h want 00", grant); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL rh_err got %b want 0", timeout_err); end
    out_ready = 1'b1; req = 8'hFF;
    tick();
    compared++; if (sel !== 3'd0) begin mismatched++; $display("FAIL rh_ptr got %0d want 0", sel); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_ready_at_limit();
    do_reset();
    dmem[4] = 16'hC0DE; out_ready = 1'b0; req = 8'h10;
    tick(); req = '0;
    tick(); tick(); tick(); tick();  // cnt now TIMEOUT-1
    compared++; if (out_valid !== 1'b1 || out_data !== 16'hC0DE) begin mismatched++; $display("FAIL lim_hold got v=%b %h want v=1 c0de", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL lim_accept got %b want 0", out_valid); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL lim_err got %b want 0", timeout_err); end
  endtask

  initial begin
    reset = 1'b0; req = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_in_hold();
    test_ready_at_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
